data_memory: RTL and testbench

Data memory stage that consumes the ALU result (effective address) and the register-file store data. It completes LW/SW, and LB/LH/SB/SH when built with sub-word support, through a fixed-latency request/ready handshake. A separate busy output lets the PC/control logic stall the core. Read data returns to the memToReg write-back mux.

---
 rtl/data_memory_pkg.sv | 26 ++
 rtl/data_memory_if.sv | 23 ++
 rtl/dmem_lane.sv | 39 +++
 rtl/data_memory.sv | 134 +++++++++++++
 tb/tb_data_memory.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_pkg.sv
// Shared encodings for the data memory stage: access sizes, FSM states, data segment base.
package data_memory_pkg;

    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;

    localparam logic [31:0] DATA_BASE = 32'h1001_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

    // Size 2'b11 is reported as misaligned so it folds into the same fault path.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return lo[0];
            SIZE_WORD: return lo != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bundle between the core (master) and the data memory stage (slave).
interface data_memory_if;
    logic        memRead;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [1:0]  size;
    logic        loadSigned;
    logic [31:0] readData;
    logic        ready;
    logic        busy;
    logic        error;

    modport master (
        output memRead, memWrite, address, writeData, size, loadSigned,
        input  readData, ready, busy, error
    );

    modport slave (
        input  memRead, memWrite, address, writeData, size, loadSigned,
        output readData, ready, busy, error
    );
endinterface

// File: rtl/dmem_lane.sv
// Little-endian lane alignment: MERGE=1 gives the store-merged word, MERGE=0 the extended load value.
module dmem_lane
    import data_memory_pkg::*;
#(
    parameter bit MERGE = 1'b0
) (
    input  logic [31:0] word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        sgn_i,
    output logic [31:0] result_o
);
    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] merged;
    logic [31:0] extracted;

    always_comb begin
        sh        = {off_i, 3'b000};
        shifted   = word_i >> sh;
        merged    = data_i;
        extracted = word_i;
        case (size_i)
            SIZE_BYTE: begin
                merged    = (word_i & ~(32'h0000_00FF << sh)) | ((data_i & 32'h0000_00FF) << sh);
                extracted = {{24{sgn_i & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                merged    = (word_i & ~(32'h0000_FFFF << sh)) | ((data_i & 32'h0000_FFFF) << sh);
                extracted = {{16{sgn_i & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

    assign result_o = MERGE ? merged : extracted;

endmodule

// File: rtl/data_memory.sv
// Data memory stage with fixed-latency request/ready handshake and busy stall output.
// Sub-word accesses (LB/LH/SB/SH) are enabled by defining DMEM_SUBWORD_EN.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = DATA_BASE,
    parameter int          LATENCY   = 2
) (
    input  logic         clk,
    input  logic         reset,
    data_memory_if.slave bus
);
    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    dmem_state_e   state_q;
    logic [3:0]    cnt_q;
    logic          write_q, fault_q, sgn_q;
    logic [1:0]    size_q, lo_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q, rdata_q, word_q;
    logic          ready_q, busy_q, error_q;
    logic [31:0]   mem_q [DEPTH] = '{default: '0};

    logic          req_any, fault_in, sample_en, commit, wr_en, sgn_in;
    logic [1:0]    size_in;
    logic [31:0]   off_in, merged, extracted;
    logic [AW-1:0] rd_idx;

`ifdef DMEM_SUBWORD_EN
    assign size_in = bus.size;
    assign sgn_in  = bus.loadSigned;
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.size, bus.loadSigned};
    assign size_in    = SIZE_WORD;
    assign sgn_in     = 1'b0;
`endif

    // Addresses below the base wrap to a huge offset and fail the span check.
    assign off_in    = bus.address - BASE_ADDR;
    assign req_any   = bus.memRead | bus.memWrite;
    assign fault_in  = (bus.memRead & bus.memWrite) | (off_in >= SPAN)
                     | misaligned(size_in, bus.address[1:0]);
    assign sample_en = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign commit    = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign wr_en     = commit && write_q && !fault_q && !reset;
    assign rd_idx    = sample_en ? off_in[AW+1:2] : idx_q;

    // The word is fetched on the accept edge and refreshed while waiting, ready for merge/extract.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx_q] <= merged;
        end
        word_q <= mem_q[rd_idx];
    end

    dmem_lane #(.MERGE(1'b1)) u_merge (
        .word_i   (word_q),
        .data_i   (wdata_q),
        .size_i   (size_q),
        .off_i    (lo_q),
        .sgn_i    (1'b0),
        .result_o (merged)
    );

    dmem_lane #(.MERGE(1'b0)) u_extract (
        .word_i   (word_q),
        .data_i   (32'd0),
        .size_i   (size_q),
        .off_i    (lo_q),
        .sgn_i    (sgn_q),
        .result_o (extracted)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            fault_q <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= SIZE_WORD;
            lo_q    <= 2'b00;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (req_any) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        write_q <= bus.memWrite & ~bus.memRead;
                        fault_q <= fault_in;
                        sgn_q   <= sgn_in;
                        size_q  <= size_in;
                        lo_q    <= bus.address[1:0];
                        idx_q   <= off_in[AW+1:2];
                        wdata_q <= bus.writeData;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_DONE;
                        ready_q <= 1'b1;
                        error_q <= fault_q;
                        rdata_q <= (fault_q || write_q) ? 32'd0 : extracted;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.readData = rdata_q;
    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_data_memory.sv
// Randomized bench for data_memory: two instances (LATENCY 2 and 1) against a byte-level reference model.
module tb_data_memory;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h1001_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] ref_bytes [4*DEPTH];

    data_memory_if b0 ();
    data_memory_if b1 ();

    assign b1.memRead    = b0.memRead;
    assign b1.memWrite   = b0.memWrite;
    assign b1.address    = b0.address;
    assign b1.writeData  = b0.writeData;
    assign b1.size       = b0.size;
    assign b1.loadSigned = b0.loadSigned;

    data_memory #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset), .bus(b0.slave));
    data_memory #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave));

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: bytes stored little-endian; applies stores that do not fault.
    task automatic ref_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [1:0] sz_in, input bit sg_in,
                              output bit err, output logic [31:0] val);
        logic [1:0] sz;
        bit sg;
        int nb;
        int off;
`ifdef DMEM_SUBWORD_EN
        sz = sz_in;
        sg = sg_in;
`else
        sz = 2'b10;
        sg = 1'b0;
`endif
        nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
        err = (rd && wr) || (nb == 0) || (a < BASE) || (a >= BASE + 4 * DEPTH) || (a % nb != 0);
        val = 32'd0;
        if (!err) begin
            off = int'(a - BASE);
            if (wr) begin
                for (int i = 0; i < nb; i++) ref_bytes[off + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_bytes[off + i];
                if (sg && nb < 4 && val[8*nb-1])
                    for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
            end
        end
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input bit sg);
        b0.memRead    = rd;
        b0.memWrite   = wr;
        b0.address    = a;
        b0.writeData  = wd;
        b0.size       = sz;
        b0.loadSigned = sg;
    endtask

    // Called at a negedge with both DUTs idle; checks latency, busy window, data and error.
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit sg, output logic [31:0] got0);
        bit exp_err;
        logic [31:0] exp_val;
        int n0, n1, k0, k1;
        logic [31:0] d0, d1;
        logic e0, e1;
        ref_access(rd, wr, a, wd, sz, sg, exp_err, exp_val);
        drive(rd, wr, a, wd, sz, sg);
        n0 = 0; n1 = 0; k0 = 0; k1 = 0;
        d0 = 32'd0; d1 = 32'd0; e0 = 1'b0; e1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                b0.memRead  = 1'b0;
                b0.memWrite = 1'b0;
            end
            check_vec("busy_lat2", 32'(b0.busy), 32'(k <= 3));
            check_vec("busy_lat1", 32'(b1.busy), 32'(k <= 2));
            if (b0.ready) begin n0++; k0 = k; d0 = b0.readData; e0 = b0.error; end
            if (b1.ready) begin n1++; k1 = k; d1 = b1.readData; e1 = b1.error; end
        end
        check_vec("ready_cnt_lat2", n0, 1);
        check_vec("ready_cnt_lat1", n1, 1);
        check_vec("ready_at_lat2", k0, 3);
        check_vec("ready_at_lat1", k1, 2);
        check_vec("error_lat2", 32'(e0), 32'(exp_err));
        check_vec("error_lat1", 32'(e1), 32'(exp_err));
        if (rd || exp_err) begin
            check_vec("rdata_lat2", d0, exp_val);
            check_vec("rdata_lat1", d1, exp_val);
        end
        $display("txn rd=%0b wr=%0b addr=%h wdata=%h size=%0d sgn=%0b -> rdata=%h err=%0b",
                 rd, wr, a, wd, sz, sg, d0, e0);
        got0 = d0;
    endtask

    task automatic b2b_test();
        int n0, n1;
        logic [31:0] d1;
        bit e;
        logic [31:0] v;
        logic [31:0] a;
        a = BASE + 32'h20;
        ref_access(1'b0, 1'b1, a, 32'hCAFE_F00D, 2'b10, 1'b0, e, v);
        drive(1'b0, 1'b1, a, 32'hCAFE_F00D, 2'b10, 1'b0);
        n0 = 0; n1 = 0; d1 = 32'd0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (b0.ready) n0++;
            if (b1.ready) begin
                n1++;
                if (n1 == 2) d1 = b1.readData;
            end
            if (k == 1) begin
                b0.memWrite = 1'b0;
            end
            if (k == 2) begin
                check_vec("b2b_sw_ready", 32'(b1.ready), 32'd1);
                drive(1'b1, 1'b0, a, 32'd0, 2'b10, 1'b0);
            end
            if (k == 3) begin
                b0.memRead = 1'b0;
                check_vec("b2b_busy_held", 32'(b1.busy), 32'd1);
            end
            if (k == 4) check_vec("b2b_lw_ready", 32'(b1.ready), 32'd1);
        end
        check_vec("busy_ignore_ready_cnt", n0, 1);
        check_vec("b2b_ready_cnt", n1, 2);
        check_vec("b2b_lw_data", d1, 32'hCAFE_F00D);
        $display("b2b sw/lw addr=%h -> rdata=%h readies lat2=%0d lat1=%0d", a, d1, n0, n1);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int sel;
        bit rd, wr;
        for (int i = 0; i < 4 * DEPTH; i++) ref_bytes[i] = 8'h00;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 2'b10, 1'b0);

        repeat (2) @(negedge clk);
        check_vec("rst_ready", {30'd0, b0.ready, b1.ready}, 32'd0);
        check_vec("rst_busy", {30'd0, b0.busy, b1.busy}, 32'd0);
        check_vec("rst_error", {30'd0, b0.error, b1.error}, 32'd0);
        check_vec("rst_rdata", b0.readData | b1.readData, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        txn(1'b0, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 2'b10, 1'b0, r);
        txn(1'b1, 1'b0, BASE + 32'h4, 32'd0, 2'b10, 1'b0, r);
        check_vec("lw_deadbeef", r, 32'hDEAD_BEEF);
        txn(1'b0, 1'b1, BASE + 32'h4, 32'd0, 2'b10, 1'b0, r);
        txn(1'b0, 1'b1, BASE + 32'h5, 32'h0000_0080, 2'b00, 1'b0, r);
        txn(1'b1, 1'b0, BASE + 32'h5, 32'd0, 2'b00, 1'b1, r);
`ifdef DMEM_SUBWORD_EN
        check_vec("lb_signed", r, 32'hFFFF_FF80);
`endif
        txn(1'b1, 1'b0, BASE + 32'h5, 32'd0, 2'b00, 1'b0, r);
`ifdef DMEM_SUBWORD_EN
        check_vec("lbu", r, 32'h0000_0080);
`endif
        txn(1'b1, 1'b0, BASE + 32'h4, 32'd0, 2'b10, 1'b0, r);
`ifdef DMEM_SUBWORD_EN
        check_vec("lw_after_sb", r, 32'h0000_8000);
`endif
        txn(1'b1, 1'b0, BASE + 32'h2, 32'd0, 2'b10, 1'b0, r);
        txn(1'b0, 1'b1, 32'h1000_FFFC, 32'h1111_1111, 2'b10, 1'b0, r);
        txn(1'b1, 1'b1, BASE + 32'h8, 32'h2222_2222, 2'b10, 1'b0, r);
        txn(1'b1, 1'b0, BASE + 32'h8, 32'd0, 2'b10, 1'b0, r);

        // Reset half a cycle after accepting a store: aborted in both instances.
        drive(1'b0, 1'b1, BASE, 32'h1234_5678, 2'b10, 1'b0);
        @(posedge clk);
        @(negedge clk);
        b0.memWrite = 1'b0;
        reset = 1'b1;
        #1;
        check_vec("midrst_busy", {30'd0, b0.busy, b1.busy}, 32'd0);
        check_vec("midrst_ready", {30'd0, b0.ready, b1.ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        $display("reset during sw addr=%h", BASE);
        @(negedge clk);
        txn(1'b1, 1'b0, BASE, 32'd0, 2'b10, 1'b0, r);
        check_vec("lw_after_abort", r, 32'h0000_0000);

        b2b_test();

        for (int t = 0; t < 80; t++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = BASE - 32'($urandom_range(1, 8));
            else if (sel == 1) a = BASE + 32'(4 * DEPTH - 4) + 32'($urandom_range(0, 7));
            else               a = BASE + 32'($urandom_range(0, 63));
            sel = $urandom_range(0, 9);
            rd  = (sel == 0) || (sel >= 5);
            wr  = (sel <= 4);
            txn(rd, wr, a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
